// File: rtl/inst_enc_pkg.sv
// Shared op classes, RV32 opcode/funct3 constants and the signed-12 range helper
// used by the instruction encoder.
package inst_enc_pkg;

  typedef enum logic [1:0] {
    OP_ADDI = 2'b00,
    OP_LW   = 2'b01,
    OP_SW   = 2'b10,
    OP_BEQ  = 2'b11
  } op_e;

  localparam logic [6:0] OPC_ADDI = 7'b0010011;
  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_BEQ  = 7'b1100011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  // An immediate is encodable when bits 31..11 are all copies of the sign bit.
  function automatic logic imm_in_range(input logic [31:0] imm);
    return imm[31:11] == {21{imm[11]}};
  endfunction

endpackage

// File: rtl/inst_encoder_imm_pack.sv
// Combinational range check and per-class field packer for the instruction encoder.
// INST_ENCODER_SATURATE_EN clamps out-of-range immediates instead of emitting a NOP.
module imm_pack
  import inst_enc_pkg::*;
(
  input  logic [1:0]  i_op,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_inst,
  output logic        o_rangeErr
);

  logic        w_inRange;
  logic [11:0] w_imm;
  logic [31:0] w_word;

  assign w_inRange  = imm_in_range(i_imm);
  assign o_rangeErr = !w_inRange;

`ifdef INST_ENCODER_SATURATE_EN
  assign w_imm = w_inRange ? i_imm[11:0] : (i_imm[31] ? 12'h800 : 12'h7FF);
`else
  assign w_imm = i_imm[11:0];
`endif

  // beq carries a halfword offset, so imm[11:0] maps onto B-type byte-offset bits 12..1.
  always_comb begin
    w_word = NOP_INST;
    case (op_e'(i_op))
      OP_ADDI: w_word = {w_imm, i_rs1, F3_ADDI, i_rd, OPC_ADDI};
      OP_LW:   w_word = {w_imm, i_rs1, F3_LW, i_rd, OPC_LW};
      OP_SW:   w_word = {w_imm[11:5], i_rs2, i_rs1, F3_SW, w_imm[4:0], OPC_SW};
      OP_BEQ:  w_word = {w_imm[11], w_imm[9:4], i_rs2, i_rs1, F3_BEQ,
                         w_imm[3:0], w_imm[10], OPC_BEQ};
      default: w_word = NOP_INST;
    endcase
  end

`ifdef INST_ENCODER_SATURATE_EN
  assign o_inst = w_word;
`else
  assign o_inst = w_inRange ? w_word : NOP_INST;
`endif

endmodule

// File: rtl/inst_encoder.sv
// Packs decoded addi/lw/sw/beq fields into RV32 words behind a registered valid/ready
// output with a saturating word-address counter. Optional macro: INST_ENCODER_SATURATE_EN.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        op_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [31:0]       imm_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              full_o,
  output logic              err_o
);

  localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] L_LAST = {ADDR_W{1'b1}};

  logic              r_valid;
  logic              r_full;
  logic              r_err;
  logic [31:0]       r_inst;
  logic [ADDR_W-1:0] r_addr;

  logic [31:0] w_word;
  logic        w_rangeErr;
  logic        w_ready;
  logic        w_accept;
  logic        w_handshake;

  imm_pack u_immPack (
    .i_op       (op_i),
    .i_rd       (rd_i),
    .i_rs1      (rs1_i),
    .i_rs2      (rs2_i),
    .i_imm      (imm_i),
    .o_inst     (w_word),
    .o_rangeErr (w_rangeErr)
  );

  assign w_handshake = r_valid && inst_ready_i;
  assign w_ready     = !r_full && (!r_valid || inst_ready_i) && !flush_i;
  assign w_accept    = in_valid_i && w_ready;

  // Flush outranks both handshakes; the counter parks on the last address once it is written.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_valid <= 1'b0;
      r_inst  <= '0;
      r_addr  <= L_BASE;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_addr  <= L_BASE;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_handshake) begin
        if (r_addr == L_LAST) begin
          r_full <= 1'b1;
        end else begin
          r_addr <= r_addr + 1'b1;
        end
      end
      if (w_accept) begin
        r_inst  <= w_word;
        r_valid <= 1'b1;
        if (w_rangeErr) begin
          r_err <= 1'b1;
        end
      end else if (w_handshake) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign in_ready_o   = w_ready;
  assign inst_valid_o = r_valid;
  assign inst_o       = r_inst;
  assign addr_o       = r_addr;
  assign full_o       = r_full;
  assign err_o        = r_err;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: randomized fields checked against an arithmetic
// RV32 encoder model plus a core-style immediate decode of every emitted word.
module tb_inst_encoder;

  localparam int AW = 2;
  localparam logic [AW-1:0] BASE = '0;
  localparam logic [AW-1:0] LAST = '1;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [1:0]  op;
    logic        bad;
  } item_t;

  logic          clk = 1'b0;
  logic          rstN, flush, inValid, inReady, instReady;
  logic [1:0]    op;
  logic [4:0]    rd, rs1, rs2;
  logic [31:0]   imm, inst;
  logic          instValid, full, err;
  logic [AW-1:0] addr;

  item_t         q[$];
  logic [AW-1:0] addrCnt = BASE;
  logic          fullExp = 1'b0;
  logic          errExp  = 1'b0;
  logic          monOn   = 1'b0;
  int            checks  = 0;
  int            errors  = 0;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk_i        (clk),
    .rst_i        (rstN),
    .flush_i      (flush),
    .in_valid_i   (inValid),
    .in_ready_o   (inReady),
    .op_i         (op),
    .rd_i         (rd),
    .rs1_i        (rs1),
    .rs2_i        (rs2),
    .imm_i        (imm),
    .inst_valid_o (instValid),
    .inst_ready_i (instReady),
    .inst_o       (inst),
    .addr_o       (addr),
    .full_o       (full),
    .err_o        (err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from field arithmetic; beq goes via the byte offset.
  function automatic logic [31:0] modelWord(input logic [1:0] o, input logic [31:0] d,
      input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] im, output logic bad);
    int signed v;
    logic [31:0] u, b;
    v = $signed(im);
    bad = (v < -2048) || (v > 2047);
    if (bad) begin
`ifdef INST_ENCODER_SATURATE_EN
      v = (v < 0) ? -2048 : 2047;
`else
      return 32'h00000013;
`endif
    end
    u = v;
    b = v * 2;
    case (o)
      2'd0:    return ((u & 32'hFFF) << 20) | (s1 << 15) | (d << 7) | 32'h13;
      2'd1:    return ((u & 32'hFFF) << 20) | (s1 << 15) | (32'd2 << 12) | (d << 7) | 32'h03;
      2'd2:    return (((u >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15) | (32'd2 << 12)
                      | ((u & 32'h1F) << 7) | 32'h23;
      default: return (((b >> 12) & 32'h1) << 31) | (((b >> 5) & 32'h3F) << 25) | (s2 << 20)
                      | (s1 << 15) | (((b >> 1) & 32'hF) << 8) | (((b >> 11) & 32'h1) << 7)
                      | 32'h63;
    endcase
  endfunction

  // What the core's immediate generator recovers from a word (beq as halfword offset).
  function automatic logic [31:0] decodeImm(input logic [1:0] o, input logic [31:0] w);
    logic [31:0] byteOff;
    case (o)
      2'd0, 2'd1: return {{20{w[31]}}, w[31:20]};
      2'd2:       return {{20{w[31]}}, w[31:25], w[11:7]};
      default: begin
        byteOff = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        return $signed(byteOff) >>> 1;
      end
    endcase
  endfunction

  task automatic applyStimulus(input logic r, input logic f, input logic v, input logic [1:0] o,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
      input logic rdy);
    logic  acc;
    item_t it;
    @(negedge clk);
    rstN = r; flush = f; inValid = v; op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
    instReady = rdy;
    #1;
    acc = r && !f && v && inReady;
    it.inst = modelWord(o, {27'b0, d}, {27'b0, s1}, {27'b0, s2}, im, it.bad);
    it.imm = im;
    it.op = o;
    @(posedge clk);
    if (acc) begin
      q.push_back(it);
      if (it.bad) errExp = 1'b1;
    end
  endtask

  task automatic monitorCycle();
    logic  validExp;
    item_t it;
    validExp = (q.size() != 0);
    checkOutput("inst_valid", {31'b0, instValid}, {31'b0, validExp});
    checkOutput("addr", {30'b0, addr}, {30'b0, addrCnt});
    checkOutput("full", {31'b0, full}, {31'b0, fullExp});
    checkOutput("err", {31'b0, err}, {31'b0, errExp});
    checkOutput("in_ready", {31'b0, inReady},
                {31'b0, !fullExp && (!validExp || instReady) && !flush});
    if (validExp) checkOutput("inst", inst, q[0].inst);
    if (!rstN || flush) begin
      q.delete();
      addrCnt = BASE;
      fullExp = 1'b0;
      errExp  = 1'b0;
    end else if (validExp && instReady) begin
      it = q.pop_front();
      if (!it.bad) checkOutput("roundtrip_imm", decodeImm(it.op, inst), it.imm);
      if (addrCnt == LAST) fullExp = 1'b1;
      else addrCnt = addrCnt + 1'b1;
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (monOn) monitorCycle();
  end

  function automatic logic [31:0] randImm();
    int sel;
    logic [31:0] edges [4];
    edges[0] = 32'h000007FF; edges[1] = 32'hFFFFF800;
    edges[2] = 32'h00000800; edges[3] = 32'hFFFFF7FF;
    sel = $urandom_range(0, 99);
    if (sel < 70) return {{20{1'b0}}, 12'($urandom_range(0, 4095))} ^ ($urandom_range(0, 1) ? 32'hFFFFF000 : 32'h0) & 32'hFFFFFFFF;
    if (sel < 85) return edges[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    rstN = 1'b0; flush = 1'b0; inValid = 1'b0; instReady = 1'b0;
    op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    monOn = 1'b1;
    #3;
    checkOutput("reset_inst", inst, 32'h0);
    checkOutput("reset_addr", {30'b0, addr}, 32'h0);
    checkOutput("reset_valid", {31'b0, instValid}, 32'h0);

    applyStimulus(1, 0, 1, 2'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1);
    #3;
    checkOutput("addi_word", inst, 32'h00500093);
    checkOutput("addi_addr", {30'b0, addr}, 32'h0);
    applyStimulus(1, 0, 1, 2'd2, 5'd0, 5'd3, 5'd2, 32'hFFFFFFFC, 1);
    #3;
    checkOutput("sw_word", inst, 32'hFE21AE23);
    applyStimulus(1, 0, 1, 2'd3, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFE, 1);
    #3;
    checkOutput("beq_word", inst, 32'hFE208EE3);

    // Stall then release: addresses 0..3 without gaps, then full.
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 1, 2'd1, 5'd4, 5'd5, 5'd0, 32'd16, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 1, 2'd0, 5'd7, 5'd7, 5'd0, 32'd100 + i, 0);
      #3;
      checkOutput("stall_in_ready", {31'b0, inReady}, 32'h0);
      checkOutput("stall_addr", {30'b0, addr}, 32'h0);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 2'd0, 5'd2, 5'd3, 5'd0, 32'd8 * i, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
    #3;
    checkOutput("full_set", {31'b0, full}, 32'h1);
    checkOutput("full_in_ready", {31'b0, inReady}, 32'h0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 1);
    #3;
    checkOutput("flush_addr", {30'b0, addr}, 32'h0);
    checkOutput("flush_full", {31'b0, full}, 32'h0);

    applyStimulus(1, 0, 1, 2'd0, 5'd0, 5'd0, 5'd0, 32'h00000800, 1);
    #3;
`ifdef INST_ENCODER_SATURATE_EN
    checkOutput("range_word", inst, 32'h7FF00013);
`else
    checkOutput("range_word", inst, 32'h00000013);
`endif
    checkOutput("range_err", {31'b0, err}, 32'h1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
    #3;
    checkOutput("err_sticky", {31'b0, err}, 32'h1);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 1);
    #3;
    checkOutput("flush_err", {31'b0, err}, 32'h0);

    applyStimulus(1, 0, 1, 2'd0, 5'd9, 5'd9, 5'd0, 32'd3, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    checkOutput("reset_mid_stall", {31'b0, instValid}, 32'h0);

    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 149) != 0), ($urandom_range(0, 11) == 0),
                    ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                    5'($urandom), 5'($urandom), 5'($urandom), randImm(),
                    ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
    #3;
    checkOutput("drain", q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
